delay_report: RTL and testbench
===============================

Name: delay_report

Overview:
- Reader/consumer side of the per-window packet-delay statistics produced by the timing block, which accumulates pktDelay and pktCount and clears them when count==limitTime.
- At each window boundary, snapshots the final totals and computes the mean delay with a serial divider.
- Queues a 4-word report record in a small FIFO.
- A host/CPU-side engine drains the FIFO one 32-bit word at a time.

Parameters:
- limitTime, 50000, window length in clk cycles; must match the timing block; legal range ≥ 40.
- DEPTH_LOG2, 2, log2 of report FIFO depth in records (default 4 records).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- count  in  32  free-running window counter from the timing block (0..limitTime).
- pktDelay  in  32  accumulated delay total from the timing block.
- pktCount  in  32  accumulated packet count from the timing block.
- rd_req  in  1  host pop request, one word per asserted cycle.
- rd_data  out  32  report word.
- rd_valid  out  1  rd_data valid, one cycle after an accepted rd_req.
- rpt_empty  out  1  FIFO holds no complete record.
- rpt_full  out  1  FIFO holds 2^DEPTH_LOG2 records.
- drop_cnt  out  16  records lost (FIFO full or engine busy), saturating at 0xFFFF.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset==0): FSM=IDLE, rd_data=0, rd_valid=0, rpt_empty=1, rpt_full=0, drop_cnt=0, busy=0, window index=0, FIFO pointers and word pointer=0. FIFO contents are not cleared.
- Capture event: count==limitTime sampled at a rising edge. pktDelay/pktCount are final in that cycle, because the timing block clears them on that same edge. The block latches snD=pktDelay, snC=pktCount, and snW=window index, then increments the window index (32-bit, wraps 0xFFFFFFFF→0).
- FSM states:
  - IDLE: on capture, go to DIV if snC≠0. If snC==0, set avg=0 and go to PUSH.
  - DIV: restoring unsigned division snD/snC, one quotient bit per cycle, exactly 32 cycles. avg=floor(snD/snC). Go to PUSH.
  - PUSH: one cycle. If rpt_full is 0, write the record {snW, snC, snD, avg} as one 128-bit FIFO entry. Otherwise, drop the record and increment drop_cnt (saturating). Return to IDLE.
- Capture to FIFO write latency: 34 cycles (division path) or 2 cycles (zero-count path).
- Capture while busy (only possible with an illegal limitTime): the new snapshot is discarded, drop_cnt increments, and the in-flight computation is unaffected.
- Read protocol:
  - rd_req with rpt_empty==0 is accepted. The next cycle, rd_valid=1 and rd_data=word[wptr], where word0=window index, word1=pktCount, word2=pktDelay, word3=avg.
  - wptr increments per accepted read. Accepting word3 pops the entry and resets wptr to 0.
  - rd_req with rpt_empty==1 is ignored: rd_valid=0 next cycle, and rd_data holds its last value.
  - rd_valid is otherwise 0.
- Simultaneous PUSH and word3 pop: fullness is evaluated from state before the edge. If full, the push is dropped even though the pop frees a slot. If not full, both complete and the occupancy is unchanged.
- Reset mid-DIV or mid-read: all state returns to reset values and the partial record is lost.
- Flags: rpt_full and rpt_empty are registered and update on the edge after the push/pop.

Decomposition:
- Shared package delay_pkg:
  - constants RPT_WORDS=4 and word indices W_IDX=0, W_CNT=1, W_DLY=2, W_AVG=3;
  - a 128-bit record typedef (fields idx, cnt, dly, avg);
  - FSM state encoding IDLE/DIV/PUSH.
- One sub-module: delay_div, a 32/32 serial restoring divider with ports start, dividend, divisor, done, quotient. Its done pulse is asserted on the 32nd cycle.
- The FIFO stays inline as a register array.

Test Plan:
- Reset, then idle: rpt_empty=1, rpt_full=0, drop_cnt=0, busy=0, rd_valid=0. rd_req for 3 cycles gives rd_valid=0 throughout.
- limitTime=100; at count==100, drive pktDelay=1000, pktCount=7. After 34 cycles rpt_empty=0. Four rd_req give rd_data 0, 7, 1000, 142 with rd_valid each cycle after the request; then rpt_empty=1.
- pktCount=0, pktDelay=0 at the boundary: the record appears 2 cycles later with avg=0 and window index=1 (second window).
- 5 windows with no reads: rpt_full=1 after the 4th record, 5th record dropped, drop_cnt=1. Reading all 16 words returns window indices 0..3 in order.
- pktDelay=0xFFFFFFFF, pktCount=1 gives avg=0xFFFFFFFF. pktDelay=5, pktCount=9 gives avg=0.
- Assert reset 10 cycles into DIV: busy=0 immediately, no record is written, and the next window's record has window index 0.

Source files
------------

// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
// Shared definitions for the delay report slice: the report record layout,
// word indices used when the host drains a record, and the FSM state encoding.
// -----------------------------------------------------------------------------
package delay_pkg;

  localparam int RPT_WORDS = 4;

  localparam logic [1:0] W_IDX = 2'd0;
  localparam logic [1:0] W_CNT = 2'd1;
  localparam logic [1:0] W_DLY = 2'd2;
  localparam logic [1:0] W_AVG = 2'd3;

  // One FIFO entry; idx lands in the most significant word.
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] cnt;
    logic [31:0] dly;
    logic [31:0] avg;
  } rpt_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PUSH = 2'd2
  } state_t;

  // Select one 32-bit word of a record in host read order.
  function automatic logic [31:0] rec_word(input rpt_rec_t rec, input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      W_IDX:   w = rec.idx;
      W_CNT:   w = rec.cnt;
      W_DLY:   w = rec.dly;
      default: w = rec.avg;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/delay_report_div.sv
// -----------------------------------------------------------------------------
// delay_div
// 32/32 unsigned serial restoring divider, one quotient bit per cycle.
//   clk, reset     : clock, asynchronous active-low reset
//   start          : load dividend/divisor (one-cycle pulse)
//   dividend       : numerator
//   divisor        : denominator (caller guarantees non-zero)
//   done           : high during the 32nd iteration cycle; quotient is final
//                    from the following cycle onward
//   quotient       : floor(dividend / divisor)
// -----------------------------------------------------------------------------
module delay_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;
  logic [4:0]  step_q, step_d;
  logic        active_q, active_d;
  logic [32:0] trial;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits shift in at the bottom. The remainder stays
  // below the divisor, so {rem, bit} never exceeds 33 bits and trial[32] is
  // a clean borrow flag.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    step_d   = step_q;
    active_d = active_q;
    trial    = {rem_q, quo_q[31]} - {1'b0, dsr_q};
    if (start) begin
      rem_d    = '0;
      quo_d    = dividend;
      dsr_d    = divisor;
      step_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = {rem_q[30:0], quo_q[31]};
        quo_d = {quo_q[30:0], 1'b0};
      end
      step_d = step_q + 5'd1;
      if (step_q == 5'd31) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      step_q   <= step_d;
      active_q <= active_d;
    end
  end

  assign done     = active_q && (step_q == 5'd31);
  assign quotient = quo_q;

endmodule

// File: rtl/delay_report.sv
// -----------------------------------------------------------------------------
// delay_report
// Consumer of the per-window delay statistics from the timing block. At each
// window boundary it snapshots the totals, computes the mean delay with a
// serial divider and queues a 4-word record that the host drains word by word.
//   clk, reset          : clock, asynchronous active-low reset
//   count               : window counter from the timing block
//   pktDelay, pktCount  : accumulated totals, final in the boundary cycle
//   rd_req              : host pop request, one word per cycle
//   rd_data, rd_valid   : report word, valid one cycle after an accepted req
//   rpt_empty, rpt_full : registered FIFO occupancy flags
//   drop_cnt            : saturating count of lost records
//   busy                : FSM not in IDLE
// -----------------------------------------------------------------------------
module delay_report #(
  parameter int unsigned limitTime  = 50000,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] count,
  input  logic [31:0] pktDelay,
  input  logic [31:0] pktCount,
  input  logic        rd_req,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rpt_empty,
  output logic        rpt_full,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  import delay_pkg::*;

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_OCC = (DEPTH_LOG2 + 1)'(DEPTH);

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [31:0]           sn_dly_q, sn_dly_d;
  logic [31:0]           sn_cnt_q, sn_cnt_d;
  logic [31:0]           sn_win_q, sn_win_d;
  logic [31:0]           win_idx_q, win_idx_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   occ_q, occ_d;
  logic [1:0]            wptr_q, wptr_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [15:0]           drop_q, drop_d;

  rpt_rec_t              mem [DEPTH];
  rpt_rec_t              push_rec;

  logic        capture, cap_accept, cap_drop;
  logic        div_start, div_done;
  logic [31:0] div_quo;
  logic        push_en, push_drop, rd_accept, pop;
  logic [16:0] drop_sum;

  // The snapshot is taken straight from the inputs at the boundary edge; the
  // FSM acts on it one cycle later from pend_q, which gives the 2-cycle
  // zero-count path and lets the divider start from registered operands.
  assign capture    = (count == limitTime);
  assign cap_accept = capture && (state_q == IDLE) && !pend_q;
  assign cap_drop   = capture && !cap_accept;
  assign div_start  = (state_q == IDLE) && pend_q && (sn_cnt_q != 32'd0);

  delay_div u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sn_dly_q),
    .divisor  (sn_cnt_q),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign push_rec.idx = sn_win_q;
  assign push_rec.cnt = sn_cnt_q;
  assign push_rec.dly = sn_dly_q;
  assign push_rec.avg = (sn_cnt_q == 32'd0) ? 32'd0 : div_quo;

  // Fullness is judged on the pre-edge flag, so a push coinciding with a
  // freeing pop is still dropped when the FIFO was full.
  assign push_en   = (state_q == PUSH) && !full_q;
  assign push_drop = (state_q == PUSH) && full_q;
  assign rd_accept = rd_req && !empty_q;
  assign pop       = rd_accept && (wptr_q == W_AVG);

  assign drop_sum  = {1'b0, drop_q} + {15'd0, cap_drop} + {15'd0, push_drop};

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    sn_dly_d  = sn_dly_q;
    sn_cnt_d  = sn_cnt_q;
    sn_win_d  = sn_win_q;
    win_idx_d = win_idx_q;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = (sn_cnt_q != 32'd0) ? DIV : PUSH;
        end
      end
      DIV:     if (div_done) state_d = PUSH;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every boundary advances the window index, including discarded ones.
    if (capture) begin
      win_idx_d = win_idx_q + 32'd1;
    end
    if (cap_accept) begin
      sn_dly_d = pktDelay;
      sn_cnt_d = pktCount;
      sn_win_d = win_idx_q;
      pend_d   = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wptr_d     = wptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_accept;
    drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + (DEPTH_LOG2)'(1);
    end
    if (rd_accept) begin
      rd_data_d = rec_word(mem[rd_ptr_q], wptr_q);
      wptr_d    = wptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (DEPTH_LOG2)'(1);
    end

    occ_d   = occ_q + {{DEPTH_LOG2{1'b0}}, push_en} - {{DEPTH_LOG2{1'b0}}, pop};
    empty_d = (occ_d == '0);
    full_d  = (occ_d == FULL_OCC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      sn_dly_q   <= '0;
      sn_cnt_q   <= '0;
      sn_win_q   <= '0;
      win_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      wptr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      sn_dly_q   <= sn_dly_d;
      sn_cnt_q   <= sn_cnt_d;
      sn_win_q   <= sn_win_d;
      win_idx_q  <= win_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
    end
  end

  // Record storage has no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q] <= push_rec;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rpt_empty = empty_q;
  assign rpt_full  = full_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_delay_report.sv
// -----------------------------------------------------------------------------
// tb_delay_report
// Self-checking bench for delay_report. A queue of expected records is filled
// at each window boundary from plain arithmetic (mean = delay / count) and
// drained as the host reads words back.
// -----------------------------------------------------------------------------
module tb_delay_report;

  import delay_pkg::*;

  localparam int unsigned LIMIT = 100;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] cnt;
    logic [31:0] dly;
    logic [31:0] avg;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] count = '0;
  logic [31:0] pktDelay = '0;
  logic [31:0] pktCount = '0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rpt_empty;
  logic        rpt_full;
  logic [15:0] drop_cnt;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t        model_q[$];
  logic [31:0] model_idx = '0;
  int          model_drop = 0;

  always #5 clk = ~clk;

  delay_report #(.limitTime(LIMIT), .DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .pktDelay  (pktDelay),
    .pktCount  (pktCount),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rpt_empty (rpt_empty),
    .rpt_full  (rpt_full),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  // Advance n cycles with a wandering counter that never hits the boundary.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      count    = $urandom_range(0, LIMIT - 1);
      pktDelay = $urandom;
      pktCount = $urandom;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    rd_req = 1'b0;
    count  = '0;
    tick(3);
    reset = 1'b1;
    tick(1);
    model_q.delete();
    model_idx  = '0;
    model_drop = 0;
  endtask

  // Present one boundary cycle and record what the design should queue.
  task automatic boundary(input logic [31:0] d, input logic [31:0] c);
    exp_t e;
    count    = LIMIT;
    pktDelay = d;
    pktCount = c;
    @(negedge clk);
    count    = $urandom_range(0, LIMIT - 1);
    pktDelay = $urandom;
    pktCount = $urandom;
    e.idx = model_idx;
    e.cnt = c;
    e.dly = d;
    e.avg = (c == 0) ? 32'd0 : d / c;
    model_idx = model_idx + 32'd1;
    if (model_q.size() < 4) model_q.push_back(e);
    else if (model_drop < 65535) model_drop++;
  endtask

  task automatic read_word(output logic [31:0] d, output logic v);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (rpt_empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty got %b want 1", rpt_empty); end
    tests_run++; if (rpt_full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full got %b want 0", rpt_full); end
    tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_drop got %0d want 0", drop_cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (rd_data !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rd_data got %h want 0", rd_data); end
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL empty_read_valid[%0d] got %b want 0", i, rd_valid); end
    end
    rd_req = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        v;
    logic [31:0] want[RPT_WORDS];
    exp_t        e;
    want = '{32'd0, 32'd7, 32'd1000, 32'd142};
    boundary(32'd1000, 32'd7);
    tick(1);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL div_busy got %b want 1", busy); end
    tick(32);
    tests_run++; if (rpt_empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat34_early got empty=%b want 1", rpt_empty); end
    tick(1);
    tests_run++; if (rpt_empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat34_write got empty=%b want 0", rpt_empty); end
    e = model_q.pop_front();
    for (int i = 0; i < RPT_WORDS; i++) begin
      read_word(d, v);
      tests_run++; if (v !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid[%0d] got %b want 1", i, v); end
      tests_run++; if (d !== want[i]) begin tests_failed++; $display("[TB] FAIL basic_word[%0d] got %0d want %0d", i, d, want[i]); end
    end
    tests_run++; if (e.avg !== want[3] || rpt_empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_drained got empty=%b want 1", rpt_empty); end
  endtask

  // Reads one full record and compares it against the model's head entry.
  task automatic test_zero();
    logic [31:0] d;
    logic        v;
    logic [31:0] want[RPT_WORDS];
    exp_t        e;
    boundary(32'd0, 32'd0);
    tick(1);
    tests_run++; if (rpt_empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat2_early got empty=%b want 1", rpt_empty); end
    tick(1);
    tests_run++; if (rpt_empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat2_write got empty=%b want 0", rpt_empty); end
    e = model_q.pop_front();
    want = '{e.idx, e.cnt, e.dly, e.avg};
    for (int i = 0; i < RPT_WORDS; i++) begin
      read_word(d, v);
      tests_run++; if (v !== 1'b1 || d !== want[i]) begin tests_failed++; $display("[TB] FAIL zero_word[%0d] got %h/%b want %h/1", i, d, v, want[i]); end
    end
    tests_run++; if (want[0] !== 32'd1) begin tests_failed++; $display("[TB] FAIL zero_window_index got %0d want 1", want[0]); end
  endtask

  task automatic test_full();
    logic [31:0] d;
    logic        v;
    logic [31:0] want[RPT_WORDS];
    exp_t        e;
    do_reset();
    for (int w = 0; w < 5; w++) begin
      boundary($urandom, $urandom_range(0, 5000));
      tick(40);
      if (w == 2) begin
        tests_run++; if (rpt_full !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_early got %b want 0", rpt_full); end
      end
      if (w == 3) begin
        tests_run++; if (rpt_full !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_after4 got %b want 1", rpt_full); end
      end
    end
    tests_run++; if (drop_cnt !== 16'(model_drop) || drop_cnt !== 16'd1) begin tests_failed++; $display("[TB] FAIL full_drop got %0d want 1", drop_cnt); end
    for (int r = 0; r < 4; r++) begin
      e = model_q.pop_front();
      want = '{e.idx, e.cnt, e.dly, e.avg};
      tests_run++; if (e.idx !== 32'(r)) begin tests_failed++; $display("[TB] FAIL full_model_idx got %0d want %0d", e.idx, r); end
      for (int i = 0; i < RPT_WORDS; i++) begin
        read_word(d, v);
        tests_run++; if (v !== 1'b1 || d !== want[i]) begin tests_failed++; $display("[TB] FAIL full_rec%0d_word%0d got %h/%b want %h/1", r, i, d, v, want[i]); end
      end
    end
    tests_run++; if (rpt_empty !== 1'b1 || rpt_full !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_drained got empty=%b full=%b want 1/0", rpt_empty, rpt_full); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic        v;
    logic [31:0] want[RPT_WORDS];
    logic [31:0] want_avg[2];
    logic [31:0] dd[2];
    logic [31:0] cc[2];
    exp_t        e;
    dd = '{32'hFFFF_FFFF, 32'd5};
    cc = '{32'd1, 32'd9};
    want_avg = '{32'hFFFF_FFFF, 32'd0};
    for (int k = 0; k < 2; k++) begin
      boundary(dd[k], cc[k]);
      tick(40);
      e = model_q.pop_front();
      want = '{e.idx, e.cnt, e.dly, want_avg[k]};
      for (int i = 0; i < RPT_WORDS; i++) begin
        read_word(d, v);
        tests_run++; if (v !== 1'b1 || d !== want[i]) begin tests_failed++; $display("[TB] FAIL edge%0d_word%0d got %h/%b want %h/1", k, i, d, v, want[i]); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        v;
    logic [31:0] c;
    logic [31:0] want[RPT_WORDS];
    exp_t        e;
    for (int k = 0; k < 8; k++) begin
      c = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      boundary($urandom, c);
      tick($urandom_range(36, 60));
      e = model_q.pop_front();
      want = '{e.idx, e.cnt, e.dly, e.avg};
      for (int i = 0; i < RPT_WORDS; i++) begin
        read_word(d, v);
        tests_run++; if (v !== 1'b1 || d !== want[i]) begin tests_failed++; $display("[TB] FAIL rand%0d_word%0d got %h/%b want %h/1", k, i, d, v, want[i]); end
      end
    end
  endtask

  // Word3 pop lands on the same edge as the next record's push.
  task automatic test_back_to_back();
    logic [31:0] d;
    logic        v;
    logic [31:0] want[RPT_WORDS];
    exp_t        e;
    boundary($urandom, $urandom_range(1, 1000));
    tick(40);
    e = model_q.pop_front();
    want = '{e.idx, e.cnt, e.dly, e.avg};
    for (int i = 0; i < 3; i++) begin
      read_word(d, v);
      tests_run++; if (v !== 1'b1 || d !== want[i]) begin tests_failed++; $display("[TB] FAIL b2b_a_word%0d got %h/%b want %h/1", i, d, v, want[i]); end
    end
    boundary($urandom, $urandom_range(1, 1000));
    tick(33);
    read_word(d, v);
    tests_run++; if (v !== 1'b1 || d !== want[3]) begin tests_failed++; $display("[TB] FAIL b2b_a_word3 got %h/%b want %h/1", d, v, want[3]); end
    tests_run++; if (rpt_empty !== 1'b0 || rpt_full !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_occupancy got empty=%b full=%b want 0/0", rpt_empty, rpt_full); end
    e = model_q.pop_front();
    want = '{e.idx, e.cnt, e.dly, e.avg};
    for (int i = 0; i < RPT_WORDS; i++) begin
      read_word(d, v);
      tests_run++; if (v !== 1'b1 || d !== want[i]) begin tests_failed++; $display("[TB] FAIL b2b_b_word%0d got %h/%b want %h/1", i, d, v, want[i]); end
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] d;
    logic        v;
    logic [31:0] want[RPT_WORDS];
    exp_t        e;
    boundary(32'd1234, 32'd5);
    tick(10);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL middiv_busy got %b want 1", busy); end
    reset = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL middiv_reset_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
    model_idx  = '0;
    model_drop = 0;
    tick(40);
    tests_run++; if (rpt_empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL middiv_no_record got empty=%b want 1", rpt_empty); end
    boundary(32'd777, 32'd3);
    tick(40);
    e = model_q.pop_front();
    want = '{e.idx, e.cnt, e.dly, e.avg};
    for (int i = 0; i < RPT_WORDS; i++) begin
      read_word(d, v);
      tests_run++; if (v !== 1'b1 || d !== want[i]) begin tests_failed++; $display("[TB] FAIL middiv_word%0d got %h/%b want %h/1", i, d, v, want[i]); end
    end
    tests_run++; if (want[0] !== 32'd0 || want[3] !== 32'd259) begin tests_failed++; $display("[TB] FAIL middiv_model got idx=%0d avg=%0d want 0/259", want[0], want[3]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_full();
    test_edge();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
